// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared widths, ready codes and FSM state encoding for the EX-stage divider
package div_unit_pkg;
    localparam int DIV_W = 32;
    localparam logic DivResultReady = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    typedef enum logic [1:0] {DivFree, DivByZero, DivOn, DivEnd} div_state_e;
endpackage

// File: rtl/div_unit_if.sv
// div_unit_if: EX-stage to divider request/result bundle
interface div_unit_if #(
    parameter int DATA_W = div_unit_pkg::DIV_W
) ();
    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  start_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;
    logic                  stallreq_o;
    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, stallreq_o
    );
    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, stallreq_o
    );
endinterface

// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring divider for DIV/DIVU, result = {remainder, quotient}
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_W = DIV_W
) (
    input  logic      clk,
    input  logic      rst,
    div_unit_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W);

    div_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_W-1:0]     rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic                  nq_q, nq_d, nr_q, nr_d, rdy_q, rdy_d;
    logic [2*DATA_W-1:0]   res_q, res_d;
    logic                  go, s1, s2;
    logic [DATA_W:0]       trial, diff;
    logic [DATA_W-1:0]     rem_n, quo_n;

    assign go = bus.start_i & ~bus.annul_i;
    assign s1 = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
    assign s2 = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
    // quo_q doubles as the dividend shift register; its MSB feeds the partial remainder
    assign trial = {rem_q, quo_q[DATA_W-1]};
    assign diff = trial - {1'b0, dvs_q};
    assign rem_n = diff[DATA_W] ? trial[DATA_W-1:0] : diff[DATA_W-1:0];
    assign quo_n = {quo_q[DATA_W-2:0], ~diff[DATA_W]};

    assign bus.result_o = res_q;
    assign bus.ready_o = rdy_q;
    assign bus.stallreq_o = bus.start_i & ~rdy_q & ~bus.annul_i;

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        nq_d = nq_q;
        nr_d = nr_q;
        rdy_d = rdy_q;
        res_d = res_q;
        unique case (state_q)
            DivFree: if (go) begin
                if (bus.opdata2_i == '0) state_d = DivByZero;
                else begin
                    state_d = DivOn;
                    cnt_d = '0;
                    rem_d = '0;
                    quo_d = s1 ? -bus.opdata1_i : bus.opdata1_i;
                    dvs_d = s2 ? -bus.opdata2_i : bus.opdata2_i;
                    nr_d = s1;
                    nq_d = s1 ^ s2;
                end
            end
            DivByZero: begin
                state_d = DivEnd;
                res_d = '0;
                rdy_d = DivResultReady;
            end
            DivOn: if (!go) begin
                state_d = DivFree;
                cnt_d = '0;
                rdy_d = DivResultNotReady;
                res_d = '0;
            end else begin
                rem_d = rem_n;
                quo_d = quo_n;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = DivEnd;
                    rdy_d = DivResultReady;
                    res_d = {nr_q ? -rem_n : rem_n, nq_q ? -quo_n : quo_n};
                end
            end
            DivEnd: if (!go) begin
                state_d = DivFree;
                rdy_d = DivResultNotReady;
                res_d = '0;
            end
            default: state_d = DivFree;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DivFree;
            cnt_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            nq_q <= 1'b0;
            nr_q <= 1'b0;
            rdy_q <= DivResultNotReady;
            res_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
            nq_q <= nq_d;
            nr_q <= nr_d;
            rdy_q <= rdy_d;
            res_q <= res_d;
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed scoreboard bench for div_unit latency, results, abort and async reset
module tb_div_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    logic [63:0] sb[$];

    div_unit_if #(.DATA_W(32)) bus ();
    div_unit #(.DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // called just after a falling edge; returns just after a falling edge
    task automatic do_div(input string tag, input logic sd, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int lat);
        int n;
        int stall;
        logic [63:0] want;
        bus.signed_div_i = sd;
        bus.opdata1_i = a;
        bus.opdata2_i = b;
        bus.annul_i = 1'b0;
        bus.start_i = 1'b1;
        sb.push_back(exp);
        #1;
        stall = bus.stallreq_o ? 1 : 0;
        n = 0;
        while (!bus.ready_o && n < 100) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                bus.opdata1_i = ~a;
                bus.opdata2_i = b ^ 32'h5;
            end
            if (!bus.ready_o && bus.stallreq_o) stall++;
        end
        want = sb.pop_front();
        chk({tag, "_lat"}, 64'(n), 64'(lat));
        chk({tag, "_stall"}, 64'(stall), 64'(lat));
        chk({tag, "_res"}, bus.result_o, want);
        chk({tag, "_stall_rdy"}, 64'(bus.stallreq_o), 64'd0);
        @(negedge clk);
        chk({tag, "_hold"}, {bus.result_o[62:0], bus.ready_o}, {want[62:0], 1'b1});
        bus.start_i = 1'b0;
        @(negedge clk);
        chk({tag, "_drop"}, {bus.result_o[62:0], bus.ready_o}, 64'd0);
    endtask

    initial begin
        bus.signed_div_i = 1'b0;
        bus.opdata1_i = '0;
        bus.opdata2_i = '0;
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("rst_async", {bus.result_o[61:0], bus.ready_o, bus.stallreq_o}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_state", {bus.result_o[62:0], bus.ready_o}, 64'd0);

        do_div("u100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33);
        do_div("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33);
        do_div("s_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33);
        do_div("s_div0", 1'b1, 32'hFFFFFFF9, 32'd0, 64'd0, 2);
        do_div("u_div0", 1'b0, 32'd1234, 32'd0, 64'd0, 2);
        do_div("s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33);
        do_div("u_max1", 1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 33);
        do_div("u_max_m", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFE, 64'h00000001_00000001, 33);

        bus.signed_div_i = 1'b0;
        bus.opdata1_i = 32'd50;
        bus.opdata2_i = 32'd5;
        bus.start_i = 1'b1;
        bus.annul_i = 1'b1;
        #1 chk("same_annul_stall", 64'(bus.stallreq_o), 64'd0);
        repeat (3) @(negedge clk);
        chk("same_annul_rdy", 64'(bus.ready_o), 64'd0);
        do_div("after_same", 1'b0, 32'd50, 32'd5, 64'h00000000_0000000A, 33);

        begin
            int rose;
            rose = 0;
            bus.signed_div_i = 1'b0;
            bus.opdata1_i = 32'd77;
            bus.opdata2_i = 32'd4;
            bus.start_i = 1'b1;
            repeat (10) begin
                @(negedge clk);
                if (bus.ready_o) rose++;
            end
            bus.annul_i = 1'b1;
            bus.opdata1_i = 32'd9;
            bus.opdata2_i = 32'd3;
            #1 chk("annul_stall", 64'(bus.stallreq_o), 64'd0);
            repeat (40) begin
                @(negedge clk);
                if (bus.ready_o) rose++;
                if (rose == 0) bus.annul_i = 1'b0;
                if (rose == 0) bus.start_i = 1'b0;
            end
            chk("annul_no_ready", 64'(rose), 64'd0);
        end
        do_div("restart_9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33);

        begin
            int n;
            bus.signed_div_i = 1'b0;
            bus.opdata1_i = 32'd123456;
            bus.opdata2_i = 32'd10;
            bus.start_i = 1'b1;
            repeat (20) @(negedge clk);
            #2 rst = 1'b0;
            #1;
            chk("rst_run", {bus.result_o[61:0], bus.ready_o, bus.stallreq_o}, 64'd1);
            @(negedge clk);
            rst = 1'b1;
            bus.opdata1_i = 32'd13;
            bus.opdata2_i = 32'd5;
            n = 0;
            while (!bus.ready_o && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("done_res", {bus.result_o, bus.ready_o} >> 1, 64'h00000003_00000002);
            chk("done_lat", 64'(n), 64'd33);
            #2 rst = 1'b0;
            #1;
            chk("rst_done", {bus.result_o[61:0], bus.ready_o, bus.stallreq_o}, 64'd1);
            @(negedge clk);
            rst = 1'b1;
            bus.start_i = 1'b0;
            @(negedge clk);
        end
        do_div("post_rst", 1'b0, 32'd1000, 32'd10, 64'h00000000_00000064, 33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider for the EX stage. Serves DIV and DIVU.
- Requester side of the pipeline stall protocol. It raises a stall request, and the stall vector built from that request freezes IF/ID/EX.
- The EX/MEM register then injects NOPs into MEM until the quotient and remainder are ready.
- Output result_o feeds the EX-stage HI/LO write path: hi = remainder, lo = quotient.

Parameters:
- DATA_W, 32, operand width. Result is 2*DATA_W. The step counter is clog2(DATA_W) bits.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-low
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU)
- opdata1_i  in  DATA_W  dividend
- opdata2_i  in  DATA_W  divisor
- start_i  in  1  EX requests a division; held high until ready_o is seen
- annul_i  in  1  cancel the in-flight division (exception/flush)
- result_o  out  2*DATA_W  {remainder, quotient}
- ready_o  out  1  result_o valid
- stallreq_o  out  1  stall request to the pipeline controller

Behaviour:
- Reset: rst low asynchronously forces the following, with no clock edge required:
  - state = IDLE, result_o = 0, ready_o = 0, counter = 0, internal operands = 0.
- States are IDLE, ZERO, RUN and DONE.
- stallreq_o is combinational: start_i & ~ready_o & ~annul_i.
- IDLE:
  - If start_i & ~annul_i and divisor == 0, go to ZERO.
  - Otherwise, if start_i & ~annul_i, latch operands and go to RUN with counter = 0.
  - Latched operands are absolute values when signed_div_i = 1, raw values otherwise. Latched sign flags are sign(dividend) and sign(dividend) ^ sign(divisor), qualified by signed_div_i.
  - Operand changes after the latch edge are ignored.
- RUN:
  - One restoring step per edge. Shift {rem, dividend} left by 1 and trial-subtract the divisor from the upper half.
  - If the subtraction does not borrow, keep the difference and shift in quotient bit 1; else restore and shift in 0.
  - Subtraction width is DATA_W+1 so the borrow is visible.
  - After the 32nd step, go to DONE and register result_o in the same edge:
    - quotient negated if the quotient-sign flag is set;
    - remainder negated if the dividend-sign flag is set.
  - annul_i = 1 or start_i = 0 in RUN aborts to IDLE. ready_o and result_o stay 0.
- ZERO: next edge goes to DONE with result_o = 0 (MIPS leaves the result undefined; we define it as 0).
- DONE:
  - ready_o = 1 and result_o is held.
  - start_i = 0 or annul_i = 1 returns to IDLE with ready_o = 0 and result_o = 0.
  - Otherwise DONE holds; no new division starts until start_i has dropped.
- Latency, counted from edge E0 that samples start_i in IDLE:
  - Normal division: ready_o is high after E32, i.e. 33 edges inclusive of E0.
  - Divide-by-zero: ready_o is high after E1.
- Overflow: signed 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000, remainder 0. Two's-complement wrap, no trap.
- Annul and start in the same IDLE cycle: annul wins and the block stays in IDLE.

Decomposition:
- Shared defines header, alongside the existing `RegBus`/`Stop` macros:
  - state codes DivFree, DivByZero, DivOn, DivEnd (2-bit);
  - DivStart / DivStop, DivResultReady / DivResultNotReady;
  - DoubleRegBus for the 64-bit result.
- Single module. The step datapath is under 40 lines, so a separate sub-module adds nothing.

Test Plan:
- Unsigned 100 / 7, start held:
  - stallreq_o = 1 for 33 cycles;
  - ready_o rises after E32;
  - result_o = 0x00000002_0000000E;
  - dropping start_i returns to IDLE with ready_o = 0 next edge.
- Signed -7 / 2 (0xFFFFFFF9 / 0x00000002) -> result_o = 0xFFFFFFFF_FFFFFFFD (rem -1, quot -3). Also check signed 7 / -2 -> 0x00000001_FFFFFFFD.
- Divisor 0, signed and unsigned -> ready_o after E1, result_o = 0, stallreq_o low once ready.
- Signed 0x80000000 / 0xFFFFFFFF -> 0x00000000_80000000. Unsigned 0xFFFFFFFF / 1 -> 0x00000000_FFFFFFFF.
- Abort and restart:
  - annul_i pulsed at step 10 -> IDLE, ready_o never rises;
  - restart with 9 / 3 on the next edge -> 0x00000000_00000003 after 33 edges.
- Asynchronous reset mid-RUN (step 20, rst low between edges) -> result_o = 0, ready_o = 0, stallreq_o follows start_i immediately.
- After rst high, a new division completes normally.
